cfi_instr_gen: RTL and testbench

Sequencer that produces encoded CFI instruction words: landing pads, shadow-stack push/pop-check, SSRDP, and returns. It accepts one high-level request, such as a function prologue or epilogue. It then emits the matching 1–2 instruction words on a valid/ready stream. It sits in the debug/stimulus path, feeding the instruction queue or the tracer bench. It is the encoder counterpart of the tracer's CFI decode patterns.

---
 rtl/cfi_gen_pkg.sv | 85 ++++++++
 rtl/cfi_instr_encode.sv | 24 ++
 rtl/cfi_instr_gen.sv | 144 ++++++++++++++
 tb/tb_cfi_instr_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfi_gen_pkg.sv
// CFI instruction encodings and the per-beat encoder shared by the
// generator and its standalone encode wrapper.
package cfi_gen_pkg;

    localparam int unsigned LabelW = 20;

    typedef enum logic [1:0] {
        OpPrologue = 2'd0,
        OpEpilogue = 2'd1,
        OpLpadOnly = 2'd2,
        OpSsrdp    = 2'd3
    } cfi_gen_op_e;

    typedef struct packed {
        logic        is_comp;
        logic        last;
        logic [31:0] word;
    } cfi_enc_t;

    localparam logic [6:0]  OpcodeAuipc = 7'h17;
    localparam logic [31:0] SspushX1    = 32'h8210_4073;
    localparam logic [31:0] SspushX5    = 32'h8250_4073;
    localparam logic [31:0] SspopchkX1  = 32'h81C0_C073;
    localparam logic [31:0] SspopchkX5  = 32'h81C2_C073;
    localparam logic [31:0] SsrdpBase   = 32'h81D0_4073;
    localparam logic [31:0] RetX1       = 32'h0000_8067;
    localparam logic [31:0] RetX5       = 32'h0002_8067;
    localparam logic [15:0] CSspushX1   = 16'h6081;
    localparam logic [15:0] CSspopchkX5 = 16'h6281;
    localparam logic [15:0] CJrX1       = 16'h8082;
    localparam logic [15:0] CJrX5       = 16'h8282;

    // Beat 0 is the first word of a sequence, beat 1 the second.
    function automatic cfi_enc_t encode_cfi(cfi_gen_op_e op, logic beat,
                                            logic [LabelW-1:0] label,
                                            logic ra_x5, logic comp);
        cfi_enc_t    e;
        logic [31:0] lpad;
        lpad = {label, 5'b0, OpcodeAuipc};
        e    = '0;
        case (op)
            OpPrologue: begin
                if (!beat) begin
                    e.word = lpad;
                end else begin
                    e.last = 1'b1;
                    if (comp && !ra_x5) begin
                        e.is_comp = 1'b1;
                        e.word    = {16'h0, CSspushX1};
                    end else begin
                        e.word = ra_x5 ? SspushX5 : SspushX1;
                    end
                end
            end
            OpEpilogue: begin
                if (!beat) begin
                    if (comp && ra_x5) begin
                        e.is_comp = 1'b1;
                        e.word    = {16'h0, CSspopchkX5};
                    end else begin
                        e.word = ra_x5 ? SspopchkX5 : SspopchkX1;
                    end
                end else begin
                    e.last = 1'b1;
                    if (comp) begin
                        e.is_comp = 1'b1;
                        e.word    = {16'h0, (ra_x5 ? CJrX5 : CJrX1)};
                    end else begin
                        e.word = ra_x5 ? RetX5 : RetX1;
                    end
                end
            end
            OpLpadOnly: begin
                e.last = 1'b1;
                e.word = lpad;
            end
            default: begin
                e.last = 1'b1;
                e.word = SsrdpBase | {20'h0, label[4:0], 7'h0};
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/cfi_instr_encode.sv
// Combinational wrapper around encode_cfi so the encoding can be checked alone.
module cfi_instr_encode
    import cfi_gen_pkg::*;
(
    input  cfi_gen_op_e       op_i,
    input  logic              beat_i,
    input  logic [LabelW-1:0] label_i,
    input  logic              ra_x5_i,
    input  logic              comp_i,
    output logic [31:0]       instr_o,
    output logic              is_comp_o,
    output logic              last_o
);

    cfi_enc_t enc;

    always_comb begin
        enc       = encode_cfi(op_i, beat_i, label_i, ra_x5_i, comp_i);
        instr_o   = enc.word;
        is_comp_o = enc.is_comp;
        last_o    = enc.last;
    end

endmodule

// File: rtl/cfi_instr_gen.sv
// Turns one prologue/epilogue/lpad/ssrdp request into 1-2 encoded CFI words
// on a valid/ready stream, with registered outputs and a handshake counter.
module cfi_instr_gen
    import cfi_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LABEL_W = 20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_op_i,
    input  logic [LABEL_W-1:0] req_label_i,
    input  logic               req_ra_x5_i,
    input  logic               req_comp_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic               instr_is_comp_o,
    output logic               instr_last_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   emit_cnt_o
);

    if (LABEL_W != LabelW) begin : gen_label_w_check
        $error("cfi_instr_gen: LABEL_W must be 20");
    end

    typedef enum logic [1:0] {StIdle, StEmit0, StEmit1} state_e;

    state_e             state_q;
    cfi_gen_op_e        op_q;
    logic [LABEL_W-1:0] label_q;
    logic               ra_x5_q;
    logic               comp_q;

    cfi_gen_op_e        enc_op;
    logic               enc_beat;
    logic [LABEL_W-1:0] enc_label;
    logic               enc_ra_x5;
    logic               enc_comp;
    logic [31:0]        enc_word;
    logic               enc_is_comp;
    logic               enc_last;
    logic               handshake;

    assign handshake   = instr_valid_o && instr_ready_i;
    assign req_ready_o = (state_q == StIdle) && !flush_i;
    assign busy_o      = (state_q != StIdle);

    // In idle we encode the incoming request's first word; otherwise the latched
    // request's second word, which is only consumed on the EMIT0 -> EMIT1 step.
    always_comb begin
        enc_op    = op_q;
        enc_beat  = 1'b1;
        enc_label = label_q;
        enc_ra_x5 = ra_x5_q;
        enc_comp  = comp_q;
        if (state_q == StIdle) begin
            enc_op    = cfi_gen_op_e'(req_op_i);
            enc_beat  = 1'b0;
            enc_label = req_label_i;
            enc_ra_x5 = req_ra_x5_i;
            enc_comp  = req_comp_i;
        end
    end

    cfi_instr_encode u_encode (
        .op_i      (enc_op),
        .beat_i    (enc_beat),
        .label_i   (enc_label),
        .ra_x5_i   (enc_ra_x5),
        .comp_i    (enc_comp),
        .instr_o   (enc_word),
        .is_comp_o (enc_is_comp),
        .last_o    (enc_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            op_q            <= OpPrologue;
            label_q         <= '0;
            ra_x5_q         <= 1'b0;
            comp_q          <= 1'b0;
            instr_valid_o   <= 1'b0;
            instr_o         <= '0;
            instr_is_comp_o <= 1'b0;
            instr_last_o    <= 1'b0;
            emit_cnt_o      <= '0;
        end else begin
            // A handshake in the same cycle as a flush still counts.
            if (handshake) begin
                emit_cnt_o <= emit_cnt_o + 1'b1;
            end
            if (flush_i) begin
                state_q       <= StIdle;
                instr_valid_o <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (req_valid_i) begin
                            op_q            <= cfi_gen_op_e'(req_op_i);
                            label_q         <= req_label_i;
                            ra_x5_q         <= req_ra_x5_i;
                            comp_q          <= req_comp_i;
                            state_q         <= StEmit0;
                            instr_valid_o   <= 1'b1;
                            instr_o         <= enc_word;
                            instr_is_comp_o <= enc_is_comp;
                            instr_last_o    <= enc_last;
                        end
                    end
                    StEmit0: begin
                        if (instr_ready_i) begin
                            if (instr_last_o) begin
                                state_q       <= StIdle;
                                instr_valid_o <= 1'b0;
                            end else begin
                                state_q         <= StEmit1;
                                instr_o         <= enc_word;
                                instr_is_comp_o <= enc_is_comp;
                                instr_last_o    <= enc_last;
                            end
                        end
                    end
                    StEmit1: begin
                        if (instr_ready_i) begin
                            state_q       <= StIdle;
                            instr_valid_o <= 1'b0;
                        end
                    end
                    default: begin
                        state_q       <= StIdle;
                        instr_valid_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfi_instr_gen.sv
// Self-checking bench for cfi_instr_gen against a sequence-level model.
module tb_cfi_instr_gen;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        req_valid_i;
    logic [1:0]  req_op_i;
    logic [19:0] req_label_i;
    logic        req_ra_x5_i;
    logic        req_comp_i;
    logic        instr_ready_i;

    logic        req_ready_o, instr_valid_o, instr_is_comp_o, instr_last_o, busy_o;
    logic [31:0] instr_o;
    logic [15:0] emit_cnt_o;

    // Narrow-counter instance on the same stimulus, used to exercise wrap-around.
    logic        req_ready_w, instr_valid_w, instr_is_comp_w, instr_last_w, busy_w;
    logic [31:0] instr_w;
    logic [3:0]  emit_cnt_w;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;
    logic [31:0] exp_w[2];
    logic        exp_c[2];
    int          exp_n;

    always #5 clk = ~clk;

    cfi_instr_gen u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_label_i     (req_label_i),
        .req_ra_x5_i     (req_ra_x5_i),
        .req_comp_i      (req_comp_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_is_comp_o (instr_is_comp_o),
        .instr_last_o    (instr_last_o),
        .busy_o          (busy_o),
        .emit_cnt_o      (emit_cnt_o)
    );

    cfi_instr_gen #(.CNT_W(4)) u_dut_w (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_w),
        .req_op_i        (req_op_i),
        .req_label_i     (req_label_i),
        .req_ra_x5_i     (req_ra_x5_i),
        .req_comp_i      (req_comp_i),
        .instr_valid_o   (instr_valid_w),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_w),
        .instr_is_comp_o (instr_is_comp_w),
        .instr_last_o    (instr_last_w),
        .busy_o          (busy_w),
        .emit_cnt_o      (emit_cnt_w)
    );

    // Expected word list for one request, straight from the instruction tables.
    function automatic void model(input logic [1:0] op, input logic [19:0] label,
                                  input logic ra5, input logic comp);
        logic [31:0] lp;
        lp = ({12'h0, label} << 12) | 32'h17;
        exp_c[0] = 1'b0;
        exp_c[1] = 1'b0;
        exp_w[1] = 32'h0;
        case (op)
            2'd0: begin
                exp_n    = 2;
                exp_w[0] = lp;
                if (comp && !ra5) begin
                    exp_w[1] = 32'h6081; exp_c[1] = 1'b1;
                end else begin
                    exp_w[1] = ra5 ? 32'h82504073 : 32'h82104073;
                end
            end
            2'd1: begin
                exp_n = 2;
                if (comp && ra5) begin
                    exp_w[0] = 32'h6281; exp_c[0] = 1'b1;
                end else begin
                    exp_w[0] = ra5 ? 32'h81C2C073 : 32'h81C0C073;
                end
                if (comp) begin
                    exp_w[1] = ra5 ? 32'h8282 : 32'h8082; exp_c[1] = 1'b1;
                end else begin
                    exp_w[1] = ra5 ? 32'h00028067 : 32'h00008067;
                end
            end
            2'd2: begin
                exp_n    = 1;
                exp_w[0] = lp;
            end
            default: begin
                exp_n    = 1;
                exp_w[0] = 32'h81D04073 | ({27'h0, label[4:0]} << 7);
            end
        endcase
    endfunction

    // mode 0: always ready; 1: random stalls (max 4); 2: 3-cycle stall on first word.
    task automatic run_req(input logic [1:0] op, input logic [19:0] label,
                           input logic ra5, input logic comp, input int mode);
        int   stalls;
        logic done;
        logic rdy;
        model(op, label, ra5, comp);
        req_op_i    = op;
        req_label_i = label;
        req_ra_x5_i = ra5;
        req_comp_i  = comp;
        req_valid_i = 1'b1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready_o);
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int b = 0; b < exp_n; b++) begin
            stalls = 0;
            done   = 1'b0;
            while (!done) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (stalls >= 4) || ($urandom_range(0, 1) == 1);
                    default: rdy = (b != 0) || (stalls >= 3);
                endcase
                instr_ready_i = rdy;
                checks++;
                if ({instr_valid_o, instr_o, instr_is_comp_o, instr_last_o,
                     instr_valid_w, instr_w, instr_is_comp_w, instr_last_w} !==
                    {2{1'b1, exp_w[b], exp_c[b], (b == exp_n - 1)}}) begin
                    errors++;
                    $display("FAIL word op=%0d beat=%0d: got v=%b w=%h c=%b l=%b want w=%h c=%b l=%b",
                             op, b, instr_valid_o, instr_o, instr_is_comp_o, instr_last_o,
                             exp_w[b], exp_c[b], (b == exp_n - 1));
                end
                @(posedge clk); #1;
                if (rdy) begin
                    done = 1'b1;
                    exp_cnt++;
                end else begin
                    stalls++;
                end
            end
        end
        instr_ready_i = 1'b0;
        checks++;
        if ({instr_valid_o, busy_o, req_ready_o, instr_valid_w, busy_w, req_ready_w} !== 6'b001001) begin
            errors++;
            $display("FAIL end_state op=%0d: got v=%b busy=%b rdy=%b want 0 0 1",
                     op, instr_valid_o, busy_o, req_ready_o);
        end
        checks++;
        if (emit_cnt_o !== exp_cnt[15:0] || emit_cnt_w !== exp_cnt[3:0]) begin
            errors++;
            $display("FAIL emit_cnt: got %0d/%0d want %0d", emit_cnt_o, emit_cnt_w, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_op_i = 2'd0;
        req_label_i = '0; req_ra_x5_i = 1'b0; req_comp_i = 1'b0; instr_ready_i = 1'b0;
        #12;
        checks++;
        if ({instr_valid_o, instr_o, instr_is_comp_o, instr_last_o, busy_o, emit_cnt_o,
             req_ready_o} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b w=%h c=%b l=%b busy=%b cnt=%0d rdy=%b",
                     instr_valid_o, instr_o, instr_is_comp_o, instr_last_o, busy_o,
                     emit_cnt_o, req_ready_o);
        end
        @(posedge clk); #1;
        rst_ni  = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_req(2'd0, 20'hABCDE, 1'b0, 1'b0, 0);
        checks++;
        if (emit_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL prologue_cnt: got %0d want 2", emit_cnt_o);
        end
        run_req(2'd1, 20'h12345, 1'b1, 1'b1, 0);
        run_req(2'd0, 20'h0F0F0, 1'b1, 1'b1, 0);
        run_req(2'd0, 20'h00001, 1'b0, 1'b1, 0);
        run_req(2'd1, 20'h00002, 1'b0, 1'b1, 0);
        run_req(2'd2, 20'hFFFFF, 1'b1, 1'b1, 0);
        run_req(2'd3, 20'h5550A, 1'b0, 1'b1, 2);
    endtask

    task automatic test_flush();
        req_op_i = 2'd1; req_label_i = 20'h0; req_ra_x5_i = 1'b0; req_comp_i = 1'b0;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0; instr_ready_i = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        instr_ready_i = 1'b0;
        checks++;
        if (instr_o !== 32'h00008067 || instr_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_emit1_word: got v=%b w=%h want 1 00008067", instr_valid_o, instr_o);
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++;
        if ({instr_valid_o, busy_o, emit_cnt_o} !== {2'b00, exp_cnt[15:0]}) begin
            errors++;
            $display("FAIL flush_emit1: got v=%b busy=%b cnt=%0d want 0 0 %0d",
                     instr_valid_o, busy_o, emit_cnt_o, exp_cnt);
        end
        // Flush coinciding with a handshake: the word still counts.
        req_op_i = 2'd0; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0; flush_i = 1'b1; instr_ready_i = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        flush_i = 1'b0; instr_ready_i = 1'b0;
        checks++;
        if ({instr_valid_o, busy_o, emit_cnt_o, emit_cnt_w} !==
            {2'b00, exp_cnt[15:0], exp_cnt[3:0]}) begin
            errors++;
            $display("FAIL flush_handshake: got v=%b busy=%b cnt=%0d want 0 0 %0d",
                     instr_valid_o, busy_o, emit_cnt_o, exp_cnt);
        end
        // Request presented together with flush in idle is refused.
        flush_i = 1'b1; req_valid_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_gates_ready: got %b want 0", req_ready_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0; req_valid_i = 1'b0;
        checks++;
        if ({instr_valid_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle_req: got v=%b busy=%b want 0 0", instr_valid_o, busy_o);
        end
        // Ready while idle does nothing.
        instr_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
        checks++;
        if (emit_cnt_o !== exp_cnt[15:0] || instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got cnt=%0d v=%b want %0d 0", emit_cnt_o, instr_valid_o, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        req_op_i = 2'd0; req_label_i = 20'h77777; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({instr_valid_o, busy_o, emit_cnt_o} !== 18'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got v=%b busy=%b cnt=%0d want 0 0 0",
                     instr_valid_o, busy_o, emit_cnt_o);
        end
        @(posedge clk); #1;
        rst_ni = 1'b1; exp_cnt = 0; instr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (instr_valid_o !== 1'b0 || emit_cnt_o !== 16'h0) begin
                errors++;
                $display("FAIL reset_mid_no_word: got v=%b cnt=%0d want 0 0", instr_valid_o, emit_cnt_o);
            end
        end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_req(2'($urandom_range(0, 3)), 20'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1);
        end
    endtask

    task automatic test_wrap();
        while (exp_cnt[3:0] != 4'hF) begin
            run_req(2'd3, 20'($urandom), 1'b0, 1'b0, 0);
        end
        checks++;
        if (emit_cnt_w !== 4'hF) begin
            errors++;
            $display("FAIL wrap_pre: got %h want F", emit_cnt_w);
        end
        run_req(2'd2, 20'h00ABC, 1'b0, 1'b0, 0);
        checks++;
        if (emit_cnt_w !== 4'h0) begin
            errors++;
            $display("FAIL wrap_zero: got %h want 0", emit_cnt_w);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_random();
        test_wrap();
        test_reset_mid();
        run_req(2'd1, 20'h0, 1'b1, 1'b0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
